// File: rtl/sobel_frame_sequencer.sv
// Frame scheduler for the Sobel edge path.
// Sequences loader -> Sobel engine -> drain, owns BRAM0 port 1 and
// supervises every busy phase with a watchdog.
module sobel_frame_sequencer #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 16,
   parameter int TIMEOUT_CYC = 65536
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic                  i_mode_run,
   input  logic                  i_abort,
   output logic                  o_ld_start,
   input  logic                  i_ld_done,
   input  logic [ADDR_WIDTH-1:0] i_ld_num_cnt,
   output logic                  o_eng_start,
   output logic                  o_eng_run,
   input  logic                  i_eng_done,
   output logic                  o_dr_start,
   input  logic                  i_dr_done,
   output logic [ADDR_WIDTH-1:0] o_num_cnt,
   input  logic                  i_ld_ce,
   input  logic                  i_ld_we,
   input  logic [ADDR_WIDTH-1:0] i_ld_addr,
   input  logic                  i_eng_ce,
   input  logic [ADDR_WIDTH-1:0] i_eng_addr,
   output logic                  b0_ce,
   output logic                  b0_we,
   output logic [ADDR_WIDTH-1:0] b0_addr,
   output logic [2:0]            o_state,
   output logic                  o_done,
   output logic                  o_err
);

   localparam int                WD_W    = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   // Reject parameter sets the watchdog and datapath cannot honour
   if (DATA_WIDTH < 1 || ADDR_WIDTH < 1 || TIMEOUT_CYC < 2) begin : g_param_check
      $fatal(1, "sobel_frame_sequencer: invalid parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_FILTER = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } state_e;

   state_e                state_q, state_d;
   logic [WD_W-1:0]       wdog_q, wdog_d;
   logic                  err_q, err_d;
   logic                  run_q, run_d;
   logic [ADDR_WIDTH-1:0] num_q, num_d;
   logic                  ld_start_q, ld_start_d;
   logic                  eng_start_q, eng_start_d;
   logic                  dr_start_q, dr_start_d;
   logic                  done_q, done_d;
   logic                  busy, expired;

   // Next-state, watchdog and registered-output decode
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      run_d   = run_q;
      num_d   = num_q;
      busy    = (state_q == S_LOAD) || (state_q == S_FILTER) || (state_q == S_DRAIN);
      expired = busy && (wdog_q == WD_LAST);

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_LOAD;
               run_d   = i_mode_run;
            end
         end
         S_LOAD: begin
            if (i_ld_done) begin
               num_d   = i_ld_num_cnt;
               state_d = (i_ld_num_cnt == '0) ? S_DONE : S_FILTER;
            end else if (expired) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end
         end
         S_FILTER: begin
            if (i_eng_done) begin
               state_d = S_DRAIN;
            end else if (expired) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end
         end
         S_DRAIN: begin
            if (i_dr_done) begin
               state_d = S_DONE;
            end else if (expired) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         S_ERR: begin
            if (i_start) begin
               state_d = S_LOAD;
               run_d   = i_mode_run;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides whatever the phase decode chose, including a
      // same-cycle done (count not latched) or a restart from ERR.
      if (i_abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         err_d   = 1'b0;
         run_d   = run_q;
         num_d   = num_q;
      end

      wdog_d      = (busy && state_d == state_q) ? wdog_q + 1'b1 : '0;
      ld_start_d  = (state_d == S_LOAD)   && (state_q != S_LOAD);
      eng_start_d = (state_d == S_FILTER) && (state_q != S_FILTER);
      dr_start_d  = (state_d == S_DRAIN)  && (state_q != S_DRAIN);
      done_d      = (state_d == S_DONE);
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wdog_q      <= '0;
         err_q       <= 1'b0;
         run_q       <= 1'b0;
         num_q       <= '0;
         ld_start_q  <= 1'b0;
         eng_start_q <= 1'b0;
         dr_start_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wdog_q      <= wdog_d;
         err_q       <= err_d;
         run_q       <= run_d;
         num_q       <= num_d;
         ld_start_q  <= ld_start_d;
         eng_start_q <= eng_start_d;
         dr_start_q  <= dr_start_d;
         done_q      <= done_d;
      end
   end

   // BRAM0 port-1 ownership follows the registered phase
   always_comb begin
      b0_ce   = 1'b0;
      b0_we   = 1'b0;
      b0_addr = '0;
      if (state_q == S_LOAD) begin
         b0_ce   = i_ld_ce;
         b0_we   = i_ld_we;
         b0_addr = i_ld_addr;
      end else if (state_q == S_FILTER) begin
         b0_ce   = i_eng_ce;
         b0_addr = i_eng_addr;
      end
   end

   assign o_state     = state_q;
   assign o_err       = err_q;
   assign o_eng_run   = run_q;
   assign o_num_cnt   = num_q;
   assign o_ld_start  = ld_start_q;
   assign o_eng_start = eng_start_q;
   assign o_dr_start  = dr_start_q;
   assign o_done      = done_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for sobel_frame_sequencer: two instances (default watchdog and a
// 16-cycle watchdog) share stimulus and are each tracked by a phase model.
module tb_sobel_frame_sequencer;

   localparam int AW = 16;
   localparam int P_IDLE = 0, P_LOAD = 1, P_FILTER = 2, P_DRAIN = 3, P_DONE = 4, P_ERR = 5;

   typedef struct {
      int ph;
      int age;
      int cnt;
      bit err, run, lds, engs, drs, done;
   } mdl_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 0, mode = 0, abort = 0, ld_done = 0, eng_done = 0, dr_done = 0;
   logic [AW-1:0] ld_num = '0;
   logic ld_ce = 0, ld_we = 0, eng_ce = 0;
   logic [AW-1:0] ld_addr = '0, eng_addr = '0;

   logic          ld_start_o[2], eng_start_o[2], eng_run_o[2], dr_start_o[2];
   logic          b0_ce_o[2], b0_we_o[2], done_o[2], err_o[2];
   logic [AW-1:0] num_o[2], b0_addr_o[2];
   logic [2:0]    state_o[2];

   int checks = 0;
   int failures = 0;
   int cnt_ld, cnt_eng, cnt_dr, cnt_done;
   int tmo[2] = '{65536, 16};
   mdl_t m[2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sobel_frame_sequencer #(
         .DATA_WIDTH (8),
         .ADDR_WIDTH (AW),
         .TIMEOUT_CYC(g == 0 ? 65536 : 16)
      ) dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_start     (start),
         .i_mode_run  (mode),
         .i_abort     (abort),
         .o_ld_start  (ld_start_o[g]),
         .i_ld_done   (ld_done),
         .i_ld_num_cnt(ld_num),
         .o_eng_start (eng_start_o[g]),
         .o_eng_run   (eng_run_o[g]),
         .i_eng_done  (eng_done),
         .o_dr_start  (dr_start_o[g]),
         .i_dr_done   (dr_done),
         .o_num_cnt   (num_o[g]),
         .i_ld_ce     (ld_ce),
         .i_ld_we     (ld_we),
         .i_ld_addr   (ld_addr),
         .i_eng_ce    (eng_ce),
         .i_eng_addr  (eng_addr),
         .b0_ce       (b0_ce_o[g]),
         .b0_we       (b0_we_o[g]),
         .b0_addr     (b0_addr_o[g]),
         .o_state     (state_o[g]),
         .o_done      (done_o[g]),
         .o_err       (err_o[g])
      );
   end

   // Phase-level reference: which phase follows, given this cycle's inputs
   function automatic mdl_t mstep(input mdl_t cur, input int limit);
      mdl_t n;
      bit busy;
      bit expired;
      n = cur;
      busy = (cur.ph == P_LOAD) || (cur.ph == P_FILTER) || (cur.ph == P_DRAIN);
      expired = busy && (cur.age == limit - 1);
      if (cur.ph != P_IDLE && abort) begin
         n.ph = P_IDLE;
         n.err = 0;
      end else if (cur.ph == P_IDLE || cur.ph == P_ERR) begin
         if (start) begin
            n.ph = P_LOAD;
            n.run = mode;
            n.err = 0;
         end
      end else if (cur.ph == P_LOAD && ld_done) begin
         n.cnt = int'(ld_num);
         n.ph = (ld_num == 0) ? P_DONE : P_FILTER;
      end else if (cur.ph == P_FILTER && eng_done) begin
         n.ph = P_DRAIN;
      end else if (cur.ph == P_DRAIN && dr_done) begin
         n.ph = P_DONE;
      end else if (cur.ph == P_DONE) begin
         n.ph = P_IDLE;
      end else if (expired) begin
         n.ph = P_ERR;
         n.err = 1;
      end
      n.age  = (n.ph == cur.ph) ? cur.age + 1 : 0;
      n.lds  = (n.ph == P_LOAD)   && (cur.ph != P_LOAD);
      n.engs = (n.ph == P_FILTER) && (cur.ph != P_FILTER);
      n.drs  = (n.ph == P_DRAIN)  && (cur.ph != P_DRAIN);
      n.done = (n.ph == P_DONE);
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         logic e_ce, e_we;
         logic [AW-1:0] e_addr;
         e_ce = 0; e_we = 0; e_addr = '0;
         if (m[k].ph == P_LOAD) begin
            e_ce = ld_ce; e_we = ld_we; e_addr = ld_addr;
         end else if (m[k].ph == P_FILTER) begin
            e_ce = eng_ce; e_addr = eng_addr;
         end
         chk($sformatf("d%0d_state", k),     32'(state_o[k]),     32'(m[k].ph));
         chk($sformatf("d%0d_err", k),       32'(err_o[k]),       32'(m[k].err));
         chk($sformatf("d%0d_eng_run", k),   32'(eng_run_o[k]),   32'(m[k].run));
         chk($sformatf("d%0d_num_cnt", k),   32'(num_o[k]),       32'(m[k].cnt));
         chk($sformatf("d%0d_ld_start", k),  32'(ld_start_o[k]),  32'(m[k].lds));
         chk($sformatf("d%0d_eng_start", k), 32'(eng_start_o[k]), 32'(m[k].engs));
         chk($sformatf("d%0d_dr_start", k),  32'(dr_start_o[k]),  32'(m[k].drs));
         chk($sformatf("d%0d_done", k),      32'(done_o[k]),      32'(m[k].done));
         chk($sformatf("d%0d_b0_ce", k),     32'(b0_ce_o[k]),     32'(e_ce));
         chk($sformatf("d%0d_b0_we", k),     32'(b0_we_o[k]),     32'(e_we));
         chk($sformatf("d%0d_b0_addr", k),   32'(b0_addr_o[k]),   32'(e_addr));
      end
   endtask

   task automatic rnd_bram();
      ld_ce = 1'($urandom); ld_we = 1'($urandom); ld_addr = AW'($urandom);
      eng_ce = 1'($urandom); eng_addr = AW'($urandom);
   endtask

   task automatic tick();
      @(posedge clk);
      for (int k = 0; k < 2; k++) m[k] = mstep(m[k], tmo[k]);
      #1;
      check_all();
      cnt_ld += int'(ld_start_o[0]);
      cnt_eng += int'(eng_start_o[0]);
      cnt_dr += int'(dr_start_o[0]);
      cnt_done += int'(done_o[0]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         rnd_bram();
         tick();
      end
   endtask

   task automatic fire(input bit s, input bit a, input bit ld, input bit eng, input bit dr);
      start = s; abort = a; ld_done = ld; eng_done = eng; dr_done = dr;
      rnd_bram();
      tick();
      start = 0; abort = 0; ld_done = 0; eng_done = 0; dr_done = 0;
   endtask

   task automatic clr_counts();
      cnt_ld = 0; cnt_eng = 0; cnt_dr = 0; cnt_done = 0;
   endtask

   initial begin
      int n;
      m[0] = '{default: 0};
      m[1] = '{default: 0};
      clr_counts();
      #12;
      check_all();
      rst_n = 1'b1;
      idle(2);

      // Full Sobel frame: 100 pixels, done pulses at +10/+50/+20
      clr_counts();
      mode = 1;
      fire(1, 0, 0, 0, 0);
      idle(9);
      ld_num = 16'd100;
      fire(0, 0, 1, 0, 0);
      idle(49);
      fire(0, 0, 0, 1, 0);
      idle(19);
      fire(0, 0, 0, 0, 1);
      idle(3);
      chk("main_ld_pulses", 32'(cnt_ld), 32'd1);
      chk("main_eng_pulses", 32'(cnt_eng), 32'd1);
      chk("main_dr_pulses", 32'(cnt_dr), 32'd1);
      chk("main_done_pulses", 32'(cnt_done), 32'd1);
      chk("main_num_cnt", 32'(num_o[0]), 32'd100);
      chk("main_eng_run", 32'(eng_run_o[0]), 32'd1);

      // Empty frame skips engine and drain
      fire(0, 1, 0, 0, 0);
      clr_counts();
      mode = 0;
      fire(1, 0, 0, 0, 0);
      idle(2);
      ld_num = '0;
      fire(0, 0, 1, 0, 0);
      idle(2);
      chk("empty_eng_pulses", 32'(cnt_eng), 32'd0);
      chk("empty_dr_pulses", 32'(cnt_dr), 32'd0);
      chk("empty_done_pulses", 32'(cnt_done), 32'd1);
      chk("empty_num_cnt", 32'(num_o[0]), 32'd0);

      // Watchdog on the 16-cycle instance, then restart from ERR
      mode = 1;
      fire(1, 0, 0, 0, 0);
      idle(1);
      ld_num = 16'd7;
      fire(0, 0, 1, 0, 0);
      n = 0;
      while (n < 40 && state_o[1] !== 3'd5) begin
         idle(1);
         n++;
      end
      chk("wd_cycles_to_err", 32'(n), 32'd16);
      chk("wd_err_flag", 32'(err_o[1]), 32'd1);
      fire(1, 0, 0, 0, 0);
      chk("wd_restart_state", 32'(state_o[1]), 32'd1);
      chk("wd_restart_err", 32'(err_o[1]), 32'd0);
      chk("wd_start_ignored_filter", 32'(state_o[0]), 32'd2);
      fire(0, 1, 0, 0, 0);

      // Abort beats a same-cycle engine done
      clr_counts();
      fire(1, 0, 0, 0, 0);
      ld_num = 16'd5;
      fire(0, 0, 1, 0, 0);
      idle(2);
      fire(0, 1, 0, 1, 0);
      idle(2);
      chk("abort_dr_pulses", 32'(cnt_dr), 32'd0);
      chk("abort_done_pulses", 32'(cnt_done), 32'd0);
      chk("abort_state", 32'(state_o[0]), 32'd0);

      // BRAM0 ownership in LOAD and FILTER
      fire(1, 0, 0, 0, 0);
      ld_ce = 1; ld_we = 1; ld_addr = 16'd5; eng_ce = 1; eng_addr = 16'd9;
      tick();
      chk("mux_load_ce", 32'(b0_ce_o[0]), 32'd1);
      chk("mux_load_we", 32'(b0_we_o[0]), 32'd1);
      chk("mux_load_addr", 32'(b0_addr_o[0]), 32'd5);
      ld_num = 16'd3;
      ld_done = 1;
      tick();
      ld_done = 0;
      chk("mux_filter_we", 32'(b0_we_o[0]), 32'd0);
      chk("mux_filter_addr", 32'(b0_addr_o[0]), 32'd9);

      // Asynchronous reset mid-FILTER, then a stray loader done in IDLE
      #2 rst_n = 1'b0;
      #1;
      m[0] = '{default: 0};
      m[1] = '{default: 0};
      check_all();
      chk("rst_state", 32'(state_o[0]), 32'd0);
      #2 rst_n = 1'b1;
      ld_num = 16'd44;
      fire(0, 0, 1, 0, 0);
      chk("stray_ld_state", 32'(state_o[0]), 32'd0);
      chk("stray_ld_num", 32'(num_o[0]), 32'd0);

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         start = ($urandom_range(0, 7) == 0);
         mode = 1'($urandom);
         abort = ($urandom_range(0, 39) == 0);
         ld_done = ($urandom_range(0, 5) == 0);
         ld_num = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
         eng_done = ($urandom_range(0, 9) == 0);
         dr_done = ($urandom_range(0, 7) == 0);
         rnd_bram();
         tick();
      end
      start = 0; abort = 0; ld_done = 0; eng_done = 0; dr_done = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
